// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU opcodes, FSM encoding and op-class helpers
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;
    localparam logic [2:0] MDU_MADD  = 3'd6;
    localparam logic [2:0] MDU_NOP   = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_MADD);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_comb.sv
// rtl/mdu_comb.sv - combinational product, quotient/remainder and MADD accumulate
module mdu_comb
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic signed [2*WIDTH-1:0] w_sa, w_sb, w_prod_s;
    logic        [2*WIDTH-1:0] w_ua, w_ub, w_prod_u, w_madd;
    logic                      w_a_neg, w_b_neg, w_b_zero;
    logic        [WIDTH-1:0]   w_a_mag, w_b_mag, w_b_safe, w_bu_safe;
    logic        [WIDTH-1:0]   w_qm, w_rm, w_q_s, w_r_s, w_q_u, w_r_u;

    assign w_sa     = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_sb     = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_ua     = {{WIDTH{1'b0}}, i_a};
    assign w_ub     = {{WIDTH{1'b0}}, i_b};
    assign w_prod_s = w_sa * w_sb;
    assign w_prod_u = w_ua * w_ub;
    assign w_madd   = {i_hi, i_lo} + w_prod_s;

    // Signed divide via magnitudes: MIN / -1 naturally yields q=MIN, r=0.
    assign w_b_zero  = (i_b == '0);
    assign w_a_neg   = i_a[WIDTH-1];
    assign w_b_neg   = i_b[WIDTH-1];
    assign w_a_mag   = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_b_mag   = w_b_neg ? (~i_b + 1'b1) : i_b;
    assign w_b_safe  = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b_mag;
    assign w_bu_safe = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : i_b;
    assign w_qm      = w_a_mag / w_b_safe;
    assign w_rm      = w_a_mag % w_b_safe;
    assign w_q_s     = (w_a_neg ^ w_b_neg) ? (~w_qm + 1'b1) : w_qm;
    assign w_r_s     = w_a_neg ? (~w_rm + 1'b1) : w_rm;
    assign w_q_u     = i_a / w_bu_safe;
    assign w_r_u     = i_a % w_bu_safe;

    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        case (i_op)
            MDU_MULT:  {o_hi, o_lo} = w_prod_s;
            MDU_MULTU: {o_hi, o_lo} = w_prod_u;
            MDU_MADD:  {o_hi, o_lo} = w_madd;
            MDU_DIV:   if (!w_b_zero) begin o_hi = w_r_s; o_lo = w_q_s; end
            MDU_DIVU:  if (!w_b_zero) begin o_hi = w_r_u; o_lo = w_q_u; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - fixed-latency multiply/divide unit owning HI/LO
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    mdu_state_t       r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_lat;
    logic [WIDTH-1:0] r_hi, r_lo, r_sh_hi, r_sh_lo, w_res_hi, w_res_lo;
    logic             w_accept, w_launch, w_commit;

    mdu_comb #(.WIDTH(WIDTH)) u_comb (
        .i_op (mdu_op),
        .i_a  (A),
        .i_b  (B),
        .i_hi (r_hi),
        .i_lo (r_lo),
        .o_hi (w_res_hi),
        .o_lo (w_res_lo)
    );

    assign w_accept = start && (r_state == ST_IDLE);
    assign w_launch = w_accept && (is_mul_op(mdu_op) || is_div_op(mdu_op));
    assign w_commit = (r_state == ST_RUN) && (r_cnt == CW'(1));
    assign w_lat    = is_mul_op(mdu_op) ? CW'(MUL_LAT) : CW'(DIV_LAT);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_launch) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_commit) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_RUN);
    end

    // Result is frozen in the shadow at launch; HI/LO only move at commit or MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_sh_hi <= '0;
            r_sh_lo <= '0;
        end else begin
            if (w_launch) begin
                r_cnt   <= w_lat;
                r_sh_hi <= w_res_hi;
                r_sh_lo <= w_res_lo;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit) begin
                r_hi <= r_sh_hi;
                r_lo <= r_sh_lo;
            end
            if (w_accept && (mdu_op == MDU_MTHI)) r_hi <= A;
            if (w_accept && (mdu_op == MDU_MTLO)) r_lo <= A;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multiply/divide unit that follows the single-cycle combinational ALU; sits beside it in the EX stage of the pipelined MIPS core.
- Executes MULT/MULTU/DIV/DIVU/MADD with fixed, parameterised multi-cycle latency, and owns the HI/LO architectural registers.
- Exposes `busy` so hazard logic can stall MFHI/MFLO and new MDU instructions.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (>=8).
- MUL_LAT, 5, busy cycles for MULT/MULTU/MADD (>=1).
- DIV_LAT, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch the operation in `mdu_op` this cycle.
- mdu_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD (signed), 7 reserved (no-op).
- A  in  WIDTH  operand rs (dividend / multiplicand / MTHI/MTLO source).
- B  in  WIDTH  operand rt (divisor / multiplier).
- busy  out  1  an operation is in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: synchronous active-high; `busy`=0, `hi`=0, `lo`=0, counter=0, shadow result=0. Reset mid-operation aborts the operation; no commit occurs.
- States: IDLE, RUN. `busy` = (state==RUN).
- Accept rule: `start` is honoured only in IDLE. `start` in RUN is ignored entirely: no queueing and no effect on `hi`/`lo`.
- MTHI/MTLO (start in IDLE):
  - `hi` (or `lo`) ← A at the same edge.
  - `busy` stays 0.
- MULT/MULTU/MADD/DIV/DIVU (start in IDLE at edge T):
  - Full result is computed combinationally from A/B/op and captured into shadow regs at T.
  - Counter ← LAT; state → RUN.
  - `busy`=1 for exactly LAT cycles (after edges T … T+LAT-1).
  - At edge T+LAT: `hi`/`lo` ← shadow, state → IDLE.
  - New values and `busy`=0 are visible together.
  - A/B may change after T without effect.
- Arithmetic:
  - MULT: {hi,lo} = signed A × signed B, 2·WIDTH-bit product.
  - MULTU: unsigned product.
  - MADD: {hi,lo} = {hi,lo} + signed(A×B), mod 2^(2·WIDTH). The {hi,lo} addend is sampled at T.
  - DIV: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Signed overflow, MIN ÷ -1: lo=MIN, hi=0.
  - Divide by zero (B==0, DIV or DIVU): still busy for DIV_LAT, then `hi`/`lo` unchanged.
- Op 7 with start: no state change, `busy` stays 0.
- Back-to-back: `start` in the same cycle `busy` falls (the IDLE cycle after commit) is accepted. MADD started then uses the just-committed {hi,lo}.
- Counter width: $clog2(max(MUL_LAT,DIV_LAT)+1).

Decomposition:
- Shared package `mdu_pkg` holds the mdu_op localparams (MDU_MULT…MDU_MADD) and the IDLE/RUN state encoding. The decode stage imports the same opcodes.
- Optional sub-module `mdu_comb` (pure combinational product/quotient/remainder and MADD accumulate). The top keeps the FSM, counter, shadow and HI/LO registers.

Test Plan:
1. Reset then MULT with A=32'hFFFF_FFFE (-2), B=3 → busy high exactly 5 cycles; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA. Same operands with MULTU → hi=32'h2, lo=32'hFFFF_FFFA.
2. DIV A=-7, B=2 → 10 busy cycles; lo=-3 (32'hFFFF_FFFD), hi=-1. DIVU A=7, B=2 → lo=3, hi=1. DIV A=32'h8000_0000, B=-1 → lo=32'h8000_0000, hi=0.
3. MTHI A=5, then MTLO A=9 → hi=5, lo=9 with busy never asserted. Then DIV B=0 → busy 10 cycles, hi=5, lo=9 retained.
4. Start MULT, then pulse start with DIVU and with MTHI at busy cycles 2 and 3 → both ignored; final hi/lo equal the MULT result; busy length still 5.
5. hi=0, lo=32'hFFFF_FFFF, MADD A=1, B=1 → hi=1, lo=0. Issue MADD again in the first IDLE cycle after commit → hi=1, lo=1.
6. Assert reset at busy cycle 3 of DIVU → next cycle busy=0, hi=lo=0, no later commit. Re-run the bench with WIDTH=16, MUL_LAT=1 → MULTU 16'hFFFF×16'hFFFF gives hi=16'hFFFE, lo=16'h0001 after a 1-cycle busy.
